// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : clock_pkg
//  Desc    : Shared mode encodings, BCD limits and BCD helper functions for
//            the time-of-day counter.
//  Rev     : 1.0  initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Binary 0-59 to a two-digit BCD pair {tens, units}.
    function automatic logic [7:0] bin2bcd(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

    // Next value of a two-digit BCD counter whose terminal count is max_bcd.
    // Terminal count and any out-of-range value both go to 00.
    function automatic logic [7:0] bcd_step(input logic [7:0] value,
                                            input logic [7:0] max_bcd);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = value[7:4];
        units = value[3:0];
        if ((value == max_bcd) || (units > 4'd9) || (tens > max_bcd[7:4]) ||
            ((tens == max_bcd[7:4]) && (units > max_bcd[3:0])))
            return 8'h00;
        else if (units == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, units + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_time_counter_bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module  : bcd2_counter
//  Desc    : Two-digit BCD modulo-MOD counter with synchronous clear and a
//            carry that fires combinationally when inc hits terminal count.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd2_counter
    import clock_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = bin2bcd(MOD - 1);

    // Digit pair register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {tens, units} <= 8'h00;
        else if (clr)
            {tens, units} <= 8'h00;
        else if (inc)
            {tens, units} <= bcd_step({tens, units}, MAX_BCD);
    end

    assign carry = inc && !clr && ({tens, units} == MAX_BCD);

endmodule
`default_nettype wire

// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module  : clock_time_counter
//  Desc    : 24 h BCD time-of-day counter with 1 Hz prescaler and a two-key
//            set mode (RUN -> SET_HOUR -> SET_MIN -> RUN).
//            Optional macro CLOCK_ALARM_EN adds the ALARM_HOUR/ALARM_MIN
//            parameters and the registered alarm output.
//  Rev     : 1.0  initial release
// ============================================================================
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000
`ifdef CLOCK_ALARM_EN
    ,
    parameter int ALARM_HOUR = 7,
    parameter int ALARM_MIN  = 0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic [3:0] h0,
    output logic [3:0] h1,
    output logic [1:0] mode,
    output logic       sec_pulse
`ifdef CLOCK_ALARM_EN
    ,
    output logic       alarm
`endif
);

    localparam int              PW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ - 1);

    mode_t         state;
    mode_t         next_state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          set_inc;
    logic          sec_clr;
    logic          sec_carry;
    logic          min_carry;
    logic          min_inc;
    logic          hour_inc;

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= MODE_RUN;
        else
            state <= next_state;
    end

    // Mode sequencing on key_mode.
    always_comb begin
        next_state = state;
        if (key_mode) begin
            case (state)
                MODE_RUN:      next_state = MODE_SET_HOUR;
                MODE_SET_HOUR: next_state = MODE_SET_MIN;
                MODE_SET_MIN:  next_state = MODE_RUN;
                default:       next_state = MODE_RUN;
            endcase
        end
    end

    assign mode = state;

    // Prescaler runs only in RUN; held at 0 while setting, so the first tick
    // after returning to RUN is a full CLK_FREQ cycles away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (state != MODE_RUN || tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign tick = (state == MODE_RUN) && (presc == PRESC_LAST);

    // sec_pulse lands on the same edge the digits advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sec_pulse <= 1'b0;
        else
            sec_pulse <= tick;
    end

    // A mode change swallows a coincident key_inc.
    assign set_inc  = key_inc && !key_mode;
    assign sec_clr  = (state == MODE_RUN) && key_mode;
    assign min_inc  = sec_carry || ((state == MODE_SET_MIN) && set_inc);
    // Minute roll-over reaches the hours only while running.
    assign hour_inc = ((state == MODE_RUN) && min_carry) ||
                      ((state == MODE_SET_HOUR) && set_inc);

    bcd2_counter #(.MOD(SEC_MAX + 1)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sec_clr),
        .inc   (tick),
        .tens  (s1),
        .units (s0),
        .carry (sec_carry)
    );

    bcd2_counter #(.MOD(MIN_MAX + 1)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (min_inc),
        .tens  (m1),
        .units (m0),
        .carry (min_carry)
    );

    bcd2_counter #(.MOD(HOUR_MAX + 1)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (hour_inc),
        .tens  (h1),
        .units (h0),
        .carry ()
    );

`ifdef CLOCK_ALARM_EN
    localparam logic [7:0] ALARM_H_BCD = bin2bcd(ALARM_HOUR);
    localparam logic [7:0] ALARM_M_BCD = bin2bcd(ALARM_MIN);
    localparam logic [7:0] MIN_BCD_MAX = bin2bcd(MIN_MAX);
    localparam logic [7:0] HR_BCD_MAX  = bin2bcd(HOUR_MAX);

    logic [7:0] min_next;
    logic [7:0] hour_next;

    // Look-ahead of the field values so alarm changes with the digit update.
    always_comb begin
        min_next  = min_inc  ? bcd_step({m1, m0}, MIN_BCD_MAX) : {m1, m0};
        hour_next = hour_inc ? bcd_step({h1, h0}, HR_BCD_MAX)  : {h1, h0};
    end

    // Alarm holds for the whole matching minute, only while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm <= 1'b0;
        else
            alarm <= (next_state == MODE_RUN) && (hour_next == ALARM_H_BCD) &&
                     (min_next == ALARM_M_BCD);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_clock_time_counter
//  Desc    : Directed self-checking bench for clock_time_counter, CLK_FREQ=10.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic [1:0] mode;
    logic       sec_pulse;
`ifdef CLOCK_ALARM_EN
    logic       alarm;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] t;
    assign t = {h1, h0, m1, m0, s1, s0};

    always #5 clk = ~clk;

    clock_time_counter #(
        .CLK_FREQ   (10)
`ifdef CLOCK_ALARM_EN
        ,
        .ALARM_HOUR (0),
        .ALARM_MIN  (1)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .s0        (s0),
        .s1        (s1),
        .m0        (m0),
        .m1        (m1),
        .h0        (h0),
        .h1        (h1),
        .mode      (mode),
        .sec_pulse (sec_pulse)
`ifdef CLOCK_ALARM_EN
        ,
        .alarm     (alarm)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic km, input logic ki);
        key_mode = km;
        key_inc  = ki;
        step(1);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        n_cmp++;
        if (t !== 24'h000000) begin n_bad++; $display("FAIL reset_time: got %h expected 000000", t); end
        n_cmp++;
        if (mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b expected 00", mode); end
        n_cmp++;
        if (sec_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0", sec_pulse); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_tick;
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (sec_pulse === 1'b1) begin pulses++; at = i; end
        end
        n_cmp++;
        if (pulses !== 1) begin n_bad++; $display("FAIL first_pulse_count: got %0d expected 1", pulses); end
        n_cmp++;
        if (at !== 10) begin n_bad++; $display("FAIL first_pulse_cycle: got %0d expected 10", at); end
        n_cmp++;
        if (t !== 24'h000001) begin n_bad++; $display("FAIL first_tick_time: got %h expected 000001", t); end
    endtask

    task automatic test_set_hour;
        int pulses;
        press(1'b1, 1'b0);
        n_cmp++;
        if (mode !== 2'b01) begin n_bad++; $display("FAIL enter_set_hour_mode: got %b expected 01", mode); end
        n_cmp++;
        if (t !== 24'h000000) begin n_bad++; $display("FAIL enter_set_hour_sec_clr: got %h expected 000000", t); end
        for (int i = 1; i <= 25; i++) begin
            press(1'b0, 1'b1);
            if (i == 23) begin
                n_cmp++;
                if (t !== 24'h230000) begin n_bad++; $display("FAIL set_hour_23: got %h expected 230000", t); end
            end
            if (i == 24) begin
                n_cmp++;
                if (t !== 24'h000000) begin n_bad++; $display("FAIL set_hour_wrap: got %h expected 000000", t); end
            end
        end
        n_cmp++;
        if (t !== 24'h010000) begin n_bad++; $display("FAIL set_hour_x25: got %h expected 010000", t); end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (sec_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || t !== 24'h010000) begin
            n_bad++; $display("FAIL set_hour_hold: got pulses=%0d time=%h expected 0 010000", pulses, t);
        end
    endtask

    task automatic test_set_min;
        int pulses;
        press(1'b1, 1'b0);
        n_cmp++;
        if (mode !== 2'b10) begin n_bad++; $display("FAIL enter_set_min_mode: got %b expected 10", mode); end
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        n_cmp++;
        if (t !== 24'h015900) begin n_bad++; $display("FAIL set_min_59: got %h expected 015900", t); end
        press(1'b0, 1'b1);
        n_cmp++;
        if (t !== 24'h010000) begin n_bad++; $display("FAIL set_min_wrap_no_carry: got %h expected 010000", t); end
        press(1'b1, 1'b1);
        n_cmp++;
        if (mode !== 2'b00 || t !== 24'h010000) begin
            n_bad++; $display("FAIL mode_beats_inc: got mode=%b time=%h expected 00 010000", mode, t);
        end
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (sec_pulse === 1'b1) pulses++;
        end
        step(1);
        n_cmp++;
        if (pulses !== 0 || sec_pulse !== 1'b1 || t !== 24'h010001) begin
            n_bad++; $display("FAIL restart_prescaler: got early=%0d pulse=%b time=%h expected 0 1 010001", pulses, sec_pulse, t);
        end
    endtask

    task automatic test_day_wrap;
        press(1'b1, 1'b0);
        for (int i = 0; i < 22; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        n_cmp++;
        if (t !== 24'h235900) begin n_bad++; $display("FAIL preload: got %h expected 235900", t); end
        press(1'b1, 1'b0);
        step(590);
        n_cmp++;
        if (t !== 24'h235959) begin n_bad++; $display("FAIL run_to_235959: got %h expected 235959", t); end
        step(9);
        n_cmp++;
        if (t !== 24'h235959) begin n_bad++; $display("FAIL hold_235959: got %h expected 235959", t); end
        step(1);
        n_cmp++;
        if (t !== 24'h000000 || mode !== 2'b00 || sec_pulse !== 1'b1) begin
            n_bad++; $display("FAIL day_wrap: got time=%h mode=%b pulse=%b expected 000000 00 1", t, mode, sec_pulse);
        end
    endtask

    task automatic test_async_reset;
        press(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        n_cmp++;
        if (t !== 24'h030000 || mode !== 2'b01) begin
            n_bad++; $display("FAIL pre_async: got time=%h mode=%b expected 030000 01", t, mode);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (t !== 24'h000000 || mode !== 2'b00 || sec_pulse !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: got time=%h mode=%b pulse=%b expected 000000 00 0", t, mode, sec_pulse);
        end
        step(1);
        rst_n = 1'b1;
    endtask

`ifdef CLOCK_ALARM_EN
    task automatic test_alarm;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(599);
        n_cmp++;
        if (alarm !== 1'b0 || t !== 24'h000059) begin
            n_bad++; $display("FAIL alarm_before: got alarm=%b time=%h expected 0 000059", alarm, t);
        end
        step(1);
        n_cmp++;
        if (alarm !== 1'b1 || t !== 24'h000100) begin
            n_bad++; $display("FAIL alarm_rise: got alarm=%b time=%h expected 1 000100", alarm, t);
        end
        step(599);
        n_cmp++;
        if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_hold: got %b expected 1", alarm); end
        step(1);
        n_cmp++;
        if (alarm !== 1'b0 || t !== 24'h000200) begin
            n_bad++; $display("FAIL alarm_fall: got alarm=%b time=%h expected 0 000200", alarm, t);
        end
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(650);
        n_cmp++;
        if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_mid_minute: got %b expected 1", alarm); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (alarm !== 1'b0 || mode !== 2'b01) begin
            n_bad++; $display("FAIL alarm_set_forced: got alarm=%b mode=%b expected 0 01", alarm, mode);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_tick();
        test_set_hour();
        test_set_min();
        test_day_wrap();
        test_async_reset();
`ifdef CLOCK_ALARM_EN
        test_alarm();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
